// File: rtl/ez8_pkg.sv
// Skip-path opcode constants, opcode decode helper and squash FSM state type.
`default_nettype none

package ez8_pkg;

  localparam logic [3:0] OP_SKIPC  = 4'b1010;
  localparam logic [3:0] OP_SKIPBS = 4'b1011;
  localparam logic [3:0] OP_SKIPBC = 4'b1100;

  typedef enum logic [0:0] {
    SKS_IDLE    = 1'b0,
    SKS_PENDING = 1'b1
  } skip_state_t;

  function automatic logic is_skip_op(input logic [3:0] op);
    return (op == OP_SKIPC) || (op == OP_SKIPBS) || (op == OP_SKIPBC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/skip_stat_ctr.sv
// +--------------------------------------------------------------------+
// | skip_stat_ctr: saturating event counter, cleared only by reset.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module skip_stat_ctr #(
    parameter int STAT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en && (count != {STAT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/skip_squash_ctrl.sv
// +--------------------------------------------------------------------+
// | skip_squash_ctrl: kills SQUASH_SLOTS real instructions after a     |
// | taken skip. Optional statistics counter: define SKIP_STATS_EN.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module skip_squash_ctrl
    import ez8_pkg::*;
#(
    parameter int SQUASH_SLOTS = 1,
    parameter int STAT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic              skip,
    input  logic              stall,
    input  logic              flush,
    input  logic              if_valid,
    output logic              squash,
    output logic              skip_busy
`ifdef SKIP_STATS_EN
    ,
    output logic [STAT_W-1:0] skip_count
`endif
);

    localparam logic [1:0] C_SLOTS = 2'(SQUASH_SLOTS);

    skip_state_t r_state;
    logic [1:0]  r_remain;
    logic        w_trigger;

    assign w_trigger = ex_valid & is_skip_op(ex_opcode) & skip & ~stall & ~flush
                     & (r_state == SKS_IDLE);

    // Bubbles and stalls leave the window open without consuming a slot.
    assign squash    = (r_state == SKS_PENDING) & if_valid & ~stall & ~flush;
    assign skip_busy = (r_state == SKS_PENDING);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= SKS_IDLE;
            r_remain <= 2'd0;
        end else if (flush) begin
            r_state  <= SKS_IDLE;
            r_remain <= 2'd0;
        end else begin
            case (r_state)
                SKS_IDLE: begin
                    if (w_trigger) begin
                        r_state  <= SKS_PENDING;
                        r_remain <= C_SLOTS;
                    end
                end
                SKS_PENDING: begin
                    if (squash) begin
                        if (r_remain == 2'd1) begin
                            r_state  <= SKS_IDLE;
                            r_remain <= 2'd0;
                        end else begin
                            r_remain <= r_remain - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= SKS_IDLE;
                    r_remain <= 2'd0;
                end
            endcase
        end
    end

`ifdef SKIP_STATS_EN
    skip_stat_ctr #(
        .STAT_W (STAT_W)
    ) u_stat (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (w_trigger),
        .count   (skip_count)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_skip_squash_ctrl.sv
// Directed bench: one-slot and two-slot instances driven with shared stimulus.
`default_nettype none

module tb_skip_squash_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ex_valid = 1'b0;
  logic [3:0] ex_opcode = 4'h0;
  logic       skip = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       if_valid = 1'b0;
  logic       sq1, bz1, sq2, bz2;
`ifdef SKIP_STATS_EN
  logic [3:0] cnt1, cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  skip_squash_ctrl #(.SQUASH_SLOTS(1), .STAT_W(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .skip(skip), .stall(stall), .flush(flush), .if_valid(if_valid),
    .squash(sq1), .skip_busy(bz1)
`ifdef SKIP_STATS_EN
    , .skip_count(cnt1)
`endif
  );

  skip_squash_ctrl #(.SQUASH_SLOTS(2), .STAT_W(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .skip(skip), .stall(stall), .flush(flush), .if_valid(if_valid),
    .squash(sq2), .skip_busy(bz2)
`ifdef SKIP_STATS_EN
    , .skip_count(cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge; outputs settle 1 ns later.
  task automatic cyc(input logic ev, input logic [3:0] op, input logic sk,
                     input logic st, input logic fl, input logic ifv);
    @(negedge clock);
    ex_valid = ev; ex_opcode = op; skip = sk; stall = st; flush = fl; if_valid = ifv;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ex_valid = 0; ex_opcode = 0; skip = 0; stall = 0; flush = 0; if_valid = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    check("rst_squash", {31'd0, sq1}, 0);
    check("rst_busy", {31'd0, bz1}, 0);
`ifdef SKIP_STATS_EN
    check("rst_count", {28'd0, cnt1}, 0);
`endif
    do_reset();

    // 1: single-slot squash
    cyc(1, 4'b1010, 1, 0, 0, 0);
    check("t1_pre_busy", {31'd0, bz1}, 0);
    check("t1_pre_squash", {31'd0, sq1}, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t1_squash", {31'd0, sq1}, 1);
    check("t1_busy", {31'd0, bz1}, 1);
    check("t1_squash2", {31'd0, sq2}, 1);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t1_done_squash", {31'd0, sq1}, 0);
    check("t1_done_busy", {31'd0, bz1}, 0);
    check("t1_slot2_second", {31'd0, sq2}, 1);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t1_slot2_idle", {31'd0, bz2}, 0);

    // 2: fetch bubbles hold the window
    do_reset();
    cyc(1, 4'b1010, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'h0, 0, 0, 0, 0);
      check("t2_bubble_squash", {31'd0, sq1}, 0);
      check("t2_bubble_busy", {31'd0, bz1}, 1);
    end
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t2_squash", {31'd0, sq1}, 1);
    check("t2_busy", {31'd0, bz1}, 1);
    cyc(0, 4'h0, 0, 0, 0, 0);
    check("t2_idle", {31'd0, bz1}, 0);

    // 3: stall holds the window
    do_reset();
    cyc(1, 4'b1010, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 4'h0, 0, 1, 0, 1);
      check("t3_stall_squash", {31'd0, sq1}, 0);
      check("t3_stall_busy", {31'd0, bz1}, 1);
    end
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t3_squash", {31'd0, sq1}, 1);
    cyc(0, 4'h0, 0, 0, 0, 0);
    check("t3_idle", {31'd0, bz1}, 0);

    // 4: flush closes window; flush beats trigger
    do_reset();
    cyc(1, 4'b1010, 1, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 1, 1);
    check("t4_flush_squash", {31'd0, sq1}, 0);
    check("t4_flush_busy", {31'd0, bz1}, 1);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t4_after_busy", {31'd0, bz1}, 0);
    check("t4_after_squash2", {31'd0, sq2}, 0);
    cyc(1, 4'b1010, 1, 0, 1, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t4_trigflush_busy", {31'd0, bz1}, 0);
    check("t4_trigflush_squash", {31'd0, sq1}, 0);

    // stall beats trigger: held skip fires once after the stall lifts
    cyc(1, 4'b1010, 1, 1, 0, 0);
    cyc(1, 4'b1010, 1, 0, 0, 0);
    check("t4_stalltrig_busy", {31'd0, bz1}, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t4_stalltrig_squash", {31'd0, sq1}, 1);

    // 5: two-slot window with a bubble; non-triggering patterns
    do_reset();
    cyc(1, 4'b1100, 1, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_sq_a", {31'd0, sq2}, 1);
    cyc(0, 4'h0, 0, 0, 0, 0);
    check("t5_sq_b", {31'd0, sq2}, 0);
    check("t5_busy_b", {31'd0, bz2}, 1);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_sq_c", {31'd0, sq2}, 1);
    check("t5_busy_c", {31'd0, bz2}, 1);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_idle", {31'd0, bz2}, 0);
    check("t5_idle_sq", {31'd0, sq2}, 0);
    cyc(1, 4'b1011, 0, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_noskip_busy", {31'd0, bz2}, 0);
    cyc(1, 4'b0101, 1, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_badop_busy", {31'd0, bz2}, 0);
    check("t5_badop_sq", {31'd0, sq1}, 0);
    cyc(0, 4'b1010, 1, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t5_invalid_busy", {31'd0, bz1}, 0);

    // 6: saturating statistics and asynchronous reset mid-window
    do_reset();
`ifdef SKIP_STATS_EN
    for (int i = 0; i < 17; i++) begin
      cyc(1, 4'b1010, 1, 0, 0, 0);
      cyc(0, 4'h0, 0, 0, 0, 1);
      if (i == 2) check("t6_count3", {28'd0, cnt1}, 32'h3);
    end
    check("t6_count_sat", {28'd0, cnt1}, 32'hF);
`endif
    cyc(1, 4'b1011, 1, 0, 0, 0);
    cyc(0, 4'h0, 0, 0, 0, 1);
    check("t6_window_open", {31'd0, sq1}, 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_squash", {31'd0, sq1}, 0);
    check("t6_rst_busy", {31'd0, bz1}, 0);
    check("t6_rst_busy2", {31'd0, bz2}, 0);
`ifdef SKIP_STATS_EN
    check("t6_rst_count", {28'd0, cnt1}, 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
